// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter.
package cdb_arbiter_pkg;

   localparam int unsigned CDB_NUM_SRC = 3;
   localparam int unsigned CDB_TAG_W   = 4;
   localparam int unsigned CDB_DATA_W  = 32;

   // Producer indices on the CDB
   localparam int unsigned SRC_ALU = 0;
   localparam int unsigned SRC_LSB = 1;
   localparam int unsigned SRC_BR  = 2;

   // Tag value meaning "no destination"; such results are never broadcast
   localparam logic [CDB_TAG_W-1:0] TAG_NONE = '0;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer handshake and CDB broadcast bundle for the arbiter.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = CDB_NUM_SRC,
   parameter int unsigned TAG_W   = CDB_TAG_W,
   parameter int unsigned DATA_W  = CDB_DATA_W
) ();

   localparam int unsigned SRC_W = $clog2(NUM_SRC);
   localparam int unsigned CNT_W = $clog2(NUM_SRC + 1);

   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC*TAG_W-1:0]  src_tag;
   logic [NUM_SRC*DATA_W-1:0] src_val;
   logic [NUM_SRC*DATA_W-1:0] src_addr;
   logic [NUM_SRC-1:0]        src_ready;

   logic                      cdb_active;
   logic [TAG_W-1:0]          cdb_tag;
   logic [DATA_W-1:0]         cdb_val;
   logic [DATA_W-1:0]         cdb_addr;
   logic [SRC_W-1:0]          cdb_src;
   logic [CNT_W-1:0]          pending;

   // Producers and CDB consumers
   modport master (
      output src_valid, src_tag, src_val, src_addr,
      input  src_ready, cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_src, pending
   );

   // The arbiter itself
   modport slave (
      input  src_valid, src_tag, src_val, src_addr,
      output src_ready, cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_src, pending
   );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first request at or after ptr wins.
module cdb_arbiter_rr_picker #(
   parameter  int unsigned N     = 3,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx
);

   logic             found;
   int unsigned      cand;
   logic [IDX_W-1:0] cand_idx;

   // Scan ptr, ptr+1, ... modulo N and grant the first requester
   always_comb begin
      grant    = '0;
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand     = (32'(ptr) + k) % N;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found           = 1'b1;
            grant[cand_idx] = 1'b1;
            idx             = cand_idx;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per producer, round-robin
// broadcast of one result per cycle, flush drops everything in flight.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = CDB_NUM_SRC,
   parameter int unsigned TAG_W   = CDB_TAG_W,
   parameter int unsigned DATA_W  = CDB_DATA_W
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   input  logic          rdy_in,
   input  logic          flush_in,
   cdb_arbiter_if.slave  bus
);

   localparam int unsigned SRC_W = $clog2(NUM_SRC);
   localparam int unsigned CNT_W = $clog2(NUM_SRC + 1);

   logic [NUM_SRC-1:0] slot_valid;
   logic [TAG_W-1:0]   slot_tag  [NUM_SRC];
   logic [DATA_W-1:0]  slot_val  [NUM_SRC];
   logic [DATA_W-1:0]  slot_addr [NUM_SRC];

   logic [SRC_W-1:0]   rr_ptr;
   logic [NUM_SRC-1:0] grant;
   logic [SRC_W-1:0]   win_idx;
   logic [NUM_SRC-1:0] accept;
   logic               live;
   logic [CNT_W-1:0]   pending_cnt;

   // Arbitrate only over occupied slots, never over same-cycle inputs
   cdb_arbiter_rr_picker #(.N(NUM_SRC)) u_rr_picker (
      .req   (slot_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx)
   );

   // A slot can take a new result when empty or being drained this edge
   assign live          = rdy_in && !flush_in;
   assign bus.src_ready = {NUM_SRC{live}} & (~slot_valid | grant);
   assign accept        = bus.src_valid & bus.src_ready;

   // Holding slots: load on handshake (None-tag results stay empty), clear on grant or flush
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         slot_valid <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            slot_tag[i]  <= '0;
            slot_val[i]  <= '0;
            slot_addr[i] <= '0;
         end
      end else if (rdy_in) begin
         if (flush_in) begin
            slot_valid <= '0;
         end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
               if (accept[i]) begin
                  slot_valid[i] <= (bus.src_tag[i*TAG_W +: TAG_W] != TAG_W'(TAG_NONE));
                  slot_tag[i]   <= bus.src_tag[i*TAG_W +: TAG_W];
                  slot_val[i]   <= bus.src_val[i*DATA_W +: DATA_W];
                  slot_addr[i]  <= bus.src_addr[i*DATA_W +: DATA_W];
               end else if (grant[i]) begin
                  slot_valid[i] <= 1'b0;
               end
            end
         end
      end
   end

   // Registered CDB broadcast and round-robin pointer
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         bus.cdb_active <= 1'b0;
         bus.cdb_tag    <= '0;
         bus.cdb_val    <= '0;
         bus.cdb_addr   <= '0;
         bus.cdb_src    <= '0;
         rr_ptr         <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            bus.cdb_active <= 1'b0;
            rr_ptr         <= '0;
         end else if (|grant) begin
            bus.cdb_active <= 1'b1;
            bus.cdb_tag    <= slot_tag[win_idx];
            bus.cdb_val    <= slot_val[win_idx];
            bus.cdb_addr   <= slot_addr[win_idx];
            bus.cdb_src    <= win_idx;
            rr_ptr         <= (win_idx == SRC_W'(NUM_SRC - 1)) ? '0 : win_idx + SRC_W'(1);
         end else begin
            bus.cdb_active <= 1'b0;
         end
      end
   end

   // Occupied-slot count
   always_comb begin
      pending_cnt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pending_cnt = pending_cnt + CNT_W'(slot_valid[i]);
      end
   end

   assign bus.pending = pending_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int unsigned NS = 3;
   localparam int unsigned TW = 4;
   localparam int unsigned DW = 32;

   logic clk_in = 1'b0;
   logic rst_n_in;
   logic rdy_in;
   logic flush_in;

   int n_checks = 0;
   int n_fail   = 0;

   cdb_arbiter_if #(.NUM_SRC(NS), .TAG_W(TW), .DATA_W(DW)) bus ();

   cdb_arbiter #(.NUM_SRC(NS), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rdy_in   (rdy_in),
      .flush_in (flush_in),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic set_src(input int i, input logic [TW-1:0] tag, input logic [DW-1:0] val,
                          input logic [DW-1:0] addr);
      bus.src_valid[i]           = 1'b1;
      bus.src_tag[i*TW +: TW]    = tag;
      bus.src_val[i*DW +: DW]    = val;
      bus.src_addr[i*DW +: DW]   = addr;
   endtask

   task automatic clear_srcs();
      bus.src_valid = '0;
      bus.src_tag   = '0;
      bus.src_val   = '0;
      bus.src_addr  = '0;
   endtask

   task automatic apply_reset();
      rst_n_in = 1'b0;
      rdy_in   = 1'b1;
      flush_in = 1'b0;
      clear_srcs();
      @(negedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0;
      rdy_in   = 1'b1;
      flush_in = 1'b0;
      clear_srcs();
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b0) begin n_fail++; $display("FAIL rst_active got %0h want 0", bus.cdb_active); end
      n_checks++; if (bus.cdb_tag !== 4'd0) begin n_fail++; $display("FAIL rst_tag got %0h want 0", bus.cdb_tag); end
      n_checks++; if (bus.cdb_val !== 32'd0) begin n_fail++; $display("FAIL rst_val got %0h want 0", bus.cdb_val); end
      n_checks++; if (bus.cdb_addr !== 32'd0) begin n_fail++; $display("FAIL rst_addr got %0h want 0", bus.cdb_addr); end
      n_checks++; if (bus.cdb_src !== 2'd0) begin n_fail++; $display("FAIL rst_src got %0h want 0", bus.cdb_src); end
      n_checks++; if (bus.pending !== 2'd0) begin n_fail++; $display("FAIL rst_pending got %0h want 0", bus.pending); end
      rst_n_in = 1'b1;
      #1;
      n_checks++; if (bus.src_ready !== 3'b111) begin n_fail++; $display("FAIL rst_ready got %b want 111", bus.src_ready); end
      // Load two slots, then hit reset mid-cycle
      @(negedge clk_in);
      set_src(0, 4'd5, 32'h55, 32'h500);
      set_src(1, 4'd6, 32'h66, 32'h600);
      @(negedge clk_in);
      clear_srcs();
      n_checks++; if (bus.pending !== 2'd2) begin n_fail++; $display("FAIL midrst_pre_pending got %0d want 2", bus.pending); end
      #2 rst_n_in = 1'b0;
      #1;
      n_checks++; if (bus.pending !== 2'd0) begin n_fail++; $display("FAIL midrst_pending got %0d want 0", bus.pending); end
      n_checks++; if (bus.cdb_active !== 1'b0) begin n_fail++; $display("FAIL midrst_active got %0h want 0", bus.cdb_active); end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b0) begin n_fail++; $display("FAIL midrst_lost got %0h want 0", bus.cdb_active); end
   endtask

   task automatic test_single();
      apply_reset();
      set_src(0, 4'd1, 32'h11, 32'h100);
      #1;
      n_checks++; if (bus.src_ready !== 3'b111) begin n_fail++; $display("FAIL single_ready got %b want 111", bus.src_ready); end
      @(negedge clk_in);
      clear_srcs();
      n_checks++; if (bus.pending !== 2'd1) begin n_fail++; $display("FAIL single_pending1 got %0d want 1", bus.pending); end
      n_checks++; if (bus.cdb_active !== 1'b0) begin n_fail++; $display("FAIL single_early got %0h want 0", bus.cdb_active); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b1) begin n_fail++; $display("FAIL single_active got %0h want 1", bus.cdb_active); end
      n_checks++; if (bus.cdb_tag !== 4'd1) begin n_fail++; $display("FAIL single_tag got %0h want 1", bus.cdb_tag); end
      n_checks++; if (bus.cdb_val !== 32'h11) begin n_fail++; $display("FAIL single_val got %0h want 11", bus.cdb_val); end
      n_checks++; if (bus.cdb_addr !== 32'h100) begin n_fail++; $display("FAIL single_addr got %0h want 100", bus.cdb_addr); end
      n_checks++; if (bus.cdb_src !== 2'd0) begin n_fail++; $display("FAIL single_src got %0d want 0", bus.cdb_src); end
      n_checks++; if (bus.pending !== 2'd0) begin n_fail++; $display("FAIL single_pending0 got %0d want 0", bus.pending); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b0) begin n_fail++; $display("FAIL single_pulse got %0h want 0", bus.cdb_active); end
   endtask

   task automatic test_all_three();
      apply_reset();
      set_src(SRC_ALU, 4'd1, 32'h21, 32'h200);
      set_src(SRC_LSB, 4'd2, 32'h22, 32'h204);
      set_src(SRC_BR,  4'd3, 32'h23, 32'h208);
      @(negedge clk_in);
      clear_srcs();
      n_checks++; if (bus.pending !== 2'd3) begin n_fail++; $display("FAIL all3_pending got %0d want 3", bus.pending); end
      n_checks++; if (bus.src_ready !== 3'b001) begin n_fail++; $display("FAIL all3_ready got %b want 001", bus.src_ready); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd1 || bus.cdb_src !== 2'd0) begin n_fail++; $display("FAIL all3_b1 got act=%0h tag=%0h src=%0d want 1/1/0", bus.cdb_active, bus.cdb_tag, bus.cdb_src); end
      n_checks++; if (bus.pending !== 2'd2) begin n_fail++; $display("FAIL all3_pend2 got %0d want 2", bus.pending); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd2 || bus.cdb_src !== 2'd1) begin n_fail++; $display("FAIL all3_b2 got act=%0h tag=%0h src=%0d want 1/2/1", bus.cdb_active, bus.cdb_tag, bus.cdb_src); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd3 || bus.cdb_src !== 2'd2) begin n_fail++; $display("FAIL all3_b3 got act=%0h tag=%0h src=%0d want 1/3/2", bus.cdb_active, bus.cdb_tag, bus.cdb_src); end
      n_checks++; if (bus.cdb_val !== 32'h23) begin n_fail++; $display("FAIL all3_val3 got %0h want 23", bus.cdb_val); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b0) begin n_fail++; $display("FAIL all3_idle got %0h want 0", bus.cdb_active); end
      n_checks++; if (bus.cdb_tag !== 4'd3) begin n_fail++; $display("FAIL all3_hold got %0h want 3", bus.cdb_tag); end
      // Pointer wrapped to 0: slot 0 must beat slot 2
      set_src(SRC_ALU, 4'd8, 32'h38, 32'h300);
      set_src(SRC_BR,  4'd9, 32'h39, 32'h304);
      @(negedge clk_in);
      clear_srcs();
      @(negedge clk_in);
      n_checks++; if (bus.cdb_tag !== 4'd8 || bus.cdb_src !== 2'd0) begin n_fail++; $display("FAIL all3_wrap1 got tag=%0h src=%0d want 8/0", bus.cdb_tag, bus.cdb_src); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_tag !== 4'd9 || bus.cdb_src !== 2'd2) begin n_fail++; $display("FAIL all3_wrap2 got tag=%0h src=%0d want 9/2", bus.cdb_tag, bus.cdb_src); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      set_src(SRC_ALU, 4'd7, 32'h77, 32'h700);
      @(negedge clk_in);
      clear_srcs();
      set_src(SRC_LSB, 4'd4, 32'h44, 32'h400);
      #1;
      n_checks++; if (bus.src_ready[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0 got %b want 1", bus.src_ready[1]); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd7 || bus.cdb_src !== 2'd0) begin n_fail++; $display("FAIL b2b_t7 got act=%0h tag=%0h src=%0d want 1/7/0", bus.cdb_active, bus.cdb_tag, bus.cdb_src); end
      set_src(SRC_LSB, 4'd5, 32'h45, 32'h404);
      #1;
      n_checks++; if (bus.src_ready[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got %b want 1", bus.src_ready[1]); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd4 || bus.cdb_src !== 2'd1) begin n_fail++; $display("FAIL b2b_t4 got act=%0h tag=%0h src=%0d want 1/4/1", bus.cdb_active, bus.cdb_tag, bus.cdb_src); end
      set_src(SRC_LSB, 4'd6, 32'h46, 32'h408);
      #1;
      n_checks++; if (bus.src_ready[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2 got %b want 1", bus.src_ready[1]); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd5) begin n_fail++; $display("FAIL b2b_t5 got act=%0h tag=%0h want 1/5", bus.cdb_active, bus.cdb_tag); end
      clear_srcs();
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd6 || bus.cdb_val !== 32'h46) begin n_fail++; $display("FAIL b2b_t6 got act=%0h tag=%0h val=%0h want 1/6/46", bus.cdb_active, bus.cdb_tag, bus.cdb_val); end
      n_checks++; if (bus.pending !== 2'd0) begin n_fail++; $display("FAIL b2b_pending got %0d want 0", bus.pending); end
   endtask

   task automatic test_flush();
      apply_reset();
      set_src(SRC_ALU, 4'd1, 32'h51, 32'h500);
      @(negedge clk_in);
      clear_srcs();
      @(negedge clk_in);
      // Pointer is now 1; refill every slot
      set_src(SRC_ALU, 4'd2, 32'h52, 32'h504);
      set_src(SRC_LSB, 4'd3, 32'h53, 32'h508);
      set_src(SRC_BR,  4'd4, 32'h54, 32'h50c);
      @(negedge clk_in);
      clear_srcs();
      n_checks++; if (bus.pending !== 2'd3) begin n_fail++; $display("FAIL flush_full got %0d want 3", bus.pending); end
      flush_in = 1'b1;
      set_src(SRC_ALU, 4'd9, 32'h59, 32'h510);
      #1;
      n_checks++; if (bus.src_ready !== 3'b000) begin n_fail++; $display("FAIL flush_ready got %b want 000", bus.src_ready); end
      @(negedge clk_in);
      flush_in = 1'b0;
      clear_srcs();
      n_checks++; if (bus.pending !== 2'd0) begin n_fail++; $display("FAIL flush_pending got %0d want 0", bus.pending); end
      n_checks++; if (bus.cdb_active !== 1'b0) begin n_fail++; $display("FAIL flush_active got %0h want 0", bus.cdb_active); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b0 || bus.pending !== 2'd0) begin n_fail++; $display("FAIL flush_drop got act=%0h pend=%0d want 0/0", bus.cdb_active, bus.pending); end
      // Pointer back at 0: slot 0 must beat slot 2
      set_src(SRC_ALU, 4'd10, 32'h5a, 32'h520);
      set_src(SRC_BR,  4'd11, 32'h5b, 32'h524);
      @(negedge clk_in);
      clear_srcs();
      @(negedge clk_in);
      n_checks++; if (bus.cdb_tag !== 4'd10 || bus.cdb_src !== 2'd0) begin n_fail++; $display("FAIL flush_rr got tag=%0h src=%0d want a/0", bus.cdb_tag, bus.cdb_src); end
      @(negedge clk_in);
   endtask

   task automatic test_pause();
      apply_reset();
      set_src(SRC_ALU, 4'd1, 32'h61, 32'h600);
      set_src(SRC_LSB, 4'd2, 32'h62, 32'h604);
      set_src(SRC_BR,  4'd3, 32'h63, 32'h608);
      @(negedge clk_in);
      clear_srcs();
      @(negedge clk_in);
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd2) begin n_fail++; $display("FAIL pause_pre got act=%0h tag=%0h want 1/2", bus.cdb_active, bus.cdb_tag); end
      rdy_in   = 1'b0;
      flush_in = 1'b1;
      set_src(SRC_ALU, 4'd9, 32'h69, 32'h610);
      #1;
      n_checks++; if (bus.src_ready !== 3'b000) begin n_fail++; $display("FAIL pause_ready got %b want 000", bus.src_ready); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk_in);
         n_checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd2 || bus.cdb_src !== 2'd1 || bus.cdb_val !== 32'h62) begin n_fail++; $display("FAIL pause_hold%0d got act=%0h tag=%0h src=%0d val=%0h want 1/2/1/62", c, bus.cdb_active, bus.cdb_tag, bus.cdb_src, bus.cdb_val); end
         n_checks++; if (bus.pending !== 2'd1) begin n_fail++; $display("FAIL pause_pend%0d got %0d want 1", c, bus.pending); end
      end
      rdy_in   = 1'b1;
      flush_in = 1'b0;
      clear_srcs();
      #1;
      n_checks++; if (bus.src_ready !== 3'b111) begin n_fail++; $display("FAIL pause_resume_ready got %b want 111", bus.src_ready); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd3 || bus.cdb_src !== 2'd2) begin n_fail++; $display("FAIL pause_resume got act=%0h tag=%0h src=%0d want 1/3/2", bus.cdb_active, bus.cdb_tag, bus.cdb_src); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b0 || bus.pending !== 2'd0) begin n_fail++; $display("FAIL pause_end got act=%0h pend=%0d want 0/0", bus.cdb_active, bus.pending); end
   endtask

   task automatic test_none_tag();
      apply_reset();
      set_src(SRC_BR, TAG_NONE, 32'h77, 32'h700);
      #1;
      n_checks++; if (bus.src_ready !== 3'b111) begin n_fail++; $display("FAIL none_ready got %b want 111", bus.src_ready); end
      @(negedge clk_in);
      clear_srcs();
      n_checks++; if (bus.pending !== 2'd0) begin n_fail++; $display("FAIL none_pending got %0d want 0", bus.pending); end
      n_checks++; if (bus.src_ready !== 3'b111) begin n_fail++; $display("FAIL none_ready2 got %b want 111", bus.src_ready); end
      @(negedge clk_in);
      n_checks++; if (bus.cdb_active !== 1'b0) begin n_fail++; $display("FAIL none_active got %0h want 0", bus.cdb_active); end
   endtask

   initial begin
      rst_n_in = 1'b0;
      rdy_in   = 1'b1;
      flush_in = 1'b0;
      clear_srcs();
      test_reset();
      test_single();
      test_all_three();
      test_back_to_back();
      test_flush();
      test_pause();
      test_none_tag();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the single common data bus (CDB) between the result producers of the out-of-order core: the ALU reservation station, the load/store buffer and the branch/jalr unit. Each producer hands over one finished result per handshake into a one-entry holding slot. The arbiter broadcasts at most one result per cycle on the registered CDB outputs, in round-robin order, to the reservation stations, the load/store buffer, the register file and the ROB. It also drops every in-flight result on a pipeline flush.

## Interface
Parameters:
- NUM_SRC, 3, number of producers; index 0 = ALU RS, 1 = LSB, 2 = branch unit
- TAG_W, 4, ROB/RS tag width; tag 0 is `None`
- DATA_W, 32, result and address width

Ports:
- clk_in  in  1  clock; all state changes on rising edge
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global enable; low = freeze all state
- flush_in  in  1  misprediction flush
- src_valid  in  NUM_SRC  producer i offers a result
- src_tag  in  NUM_SRC*TAG_W  packed tags; slice i = [i*TAG_W +: TAG_W]
- src_val  in  NUM_SRC*DATA_W  packed result values
- src_addr  in  NUM_SRC*DATA_W  packed instruction addresses
- src_ready  out  NUM_SRC  slot i can accept this cycle
- cdb_active  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_val  out  DATA_W  broadcast value
- cdb_addr  out  DATA_W  broadcast address
- cdb_src  out  $clog2(NUM_SRC)  winning producer index
- pending  out  $clog2(NUM_SRC+1)  number of occupied slots

## Operation
- State:
  - per-source slot {valid, tag, val, addr}
  - rr_ptr in 0..NUM_SRC-1
  - registered CDB outputs
- src_ready[i] = rdy_in && !flush_in && (!slot_valid[i] || grant[i]). This is combinational from registered state, plus rdy_in and flush_in.
- Accept: src_valid[i] && src_ready[i] loads slot i at the edge.
- A result offered with tag `None` is accepted and discarded; the slot stays empty.
- Arbitration:
  - Combinational over occupied slots, not over same-cycle inputs.
  - The first valid slot searching rr_ptr, rr_ptr+1, … mod NUM_SRC wins.
  - grant is one-hot or all-zero.
- Broadcast, at each edge with rdy_in=1 and flush_in=0:
  - If a grant exists: cdb_* ← winner slot, cdb_active ← 1, the winner slot is cleared (unless refilled the same edge), and rr_ptr ← (winner+1) mod NUM_SRC.
  - If no grant exists: cdb_active ← 0, other cdb_* hold, rr_ptr holds.
- cdb_active is a one-cycle pulse per result. Back-to-back results from different or the same source are allowed.
- Flush (flush_in=1, rdy_in=1):
  - All slots are cleared, cdb_active ← 0, rr_ptr ← 0.
  - Inputs that cycle are ignored.
- Pause (rdy_in=0): all registers hold, including cdb_active, and src_ready=0. flush_in is ignored while paused.
- pending = popcount(slot_valid), computed combinationally.

## Timing
- Reset: slots empty, rr_ptr=0, cdb_active=0, cdb_tag=0, cdb_val=0, cdb_addr=0, cdb_src=0. Consequently pending=0 and src_ready is all-ones once rdy_in=1.
- Reset asserted mid-operation: all state clears immediately (asynchronous) and in-flight results are lost. Deassertion is expected synchronous to clk_in.
- Latency, handshake at edge k:
  - The result sits in the slot during cycle k+1.
  - It is broadcast at edge k+1 (cdb_active high in cycle k+1→k+2) if uncontended.
- Contention with all NUM_SRC slots full: each slot is served within NUM_SRC broadcasts.
- Throughput: 1 result/cycle overall; 1 result/cycle per source while uncontended, because a slot is refilled on the same edge it is granted.
- Simultaneous flush and grant: flush wins and no broadcast occurs.

## Structure
- The shared package holds:
  - the `None` tag constant
  - TAG_W and DATA_W defaults
  - the source-index constants SRC_ALU=0, SRC_LSB=1, SRC_BR=2
- Sub-module rr_picker: combinational round-robin priority picker. Inputs are a request vector and rr_ptr; outputs are a one-hot grant and a binary index.
- Slot storage and CDB registers live in cdb_arbiter.

## Test plan
- Reset, then src_valid=3'b001, tag=1, val=0x11, addr=0x100 for one cycle → src_ready=3'b111; cdb_active for one cycle, one cycle after the handshake, with tag=1, val=0x11, cdb_src=0; pending returns to 0.
- All three sources offer in the same cycle (tags 1/2/3), rr_ptr=0 → broadcasts on three consecutive cycles in order tag 1, 2, 3; rr_ptr ends at 0.
- Source 1 offers continuously with tags 4, 5, 6 while source 0 holds tag 7 → broadcasts alternate 7, 4, 5, 6 per round-robin; neither source starves; src_ready[1] stays 1.
- Slots full (pending=3), then flush_in=1 for one cycle → pending=0 next cycle, no cdb_active, rr_ptr=0; a src_valid in the flush cycle is not accepted.
- rdy_in=0 while cdb_active=1 with tag=2 → cdb outputs and slots hold; src_ready=0. After rdy_in=1, normal broadcast of the remaining slots resumes.
- Source 2 offers tag 0 (`None`) → accepted, no broadcast, pending stays 0.
